// File: rtl/conv_pkg.sv
// Shared types and sizing for the 1-D conv datapath (conv core, MAC, output FIFO).
package conv_pkg;

    localparam int DATA_W_Y   = 11;
    localparam int FIFO_DEPTH = 4;

    typedef logic signed [DATA_W_Y-1:0] y_t;

endpackage

// File: rtl/out_fifo_mem.sv
// Storage array for the conv output FIFO: one synchronous write port, asynchronous read.
module out_fifo_mem
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_Y,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    // No reset needed: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv_out_fifo.sv
// First-word-fall-through output buffer with a registered head word for conv y results.
// Define CONV_OUT_RELU_EN to rectify negative samples as they are written.
module conv_out_fifo
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_Y,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] s_data_in_y,
    input  logic                     s_valid_y,
    output logic                     s_ready_y,
    output logic signed [DATA_W-1:0] m_data_out_y,
    output logic                     m_valid_y,
    input  logic                     m_ready_y,
    output logic [CNT_W-1:0]         fill_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         rd_next;
    logic [CNT_W-1:0]         count;
    logic                     push;
    logic                     pop;
    logic signed [DATA_W-1:0] wr_word;
    logic signed [DATA_W-1:0] next_word;
    logic signed [DATA_W-1:0] head;

    // Flags come only from the registered count, so m_ready_y never reaches s_ready_y.
    assign s_ready_y    = (count != CNT_W'(DEPTH));
    assign m_valid_y    = (count != '0);
    assign push         = s_valid_y & s_ready_y;
    assign pop          = m_valid_y & m_ready_y;
    assign rd_next      = rd_ptr + 1'b1;
    assign fill_level   = count;
    assign m_data_out_y = head;

    always_comb begin
        wr_word = s_data_in_y;
`ifdef CONV_OUT_RELU_EN
        if (s_data_in_y[DATA_W-1]) begin
            wr_word = '0;
        end
`else
`endif
    end

    out_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_next),
        .rd_data (next_word)
    );

    // The head register mirrors mem[rd_ptr]; when only one word is stored and it leaves
    // while a new one arrives, the incoming word is not in the array yet, so take it directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && (count == '0)) begin
                head <= wr_word;
            end else if (pop) begin
                if (count > CNT_W'(1)) begin
                    head <= next_word;
                end else if (push) begin
                    head <= wr_word;
                end
            end
        end
    end

endmodule
